// File: rtl/exc_ctrl.sv
// ============================================================================
// Module   : exc_ctrl
// Purpose  : MEM-stage exception/interrupt controller with CP0 (SR, Cause, EPC, PRId)
// Revision : 1.0
// ============================================================================
`default_nettype none

module exc_ctrl #(
   parameter int          NUM_IRQ      = 6,
   parameter logic [31:0] DMEM_TOP     = 32'h0000_2FFF,
   parameter int          NUM_DEV      = 2,
   parameter logic [31:0] DEV_BASE     = 32'h0000_7F00,
   parameter logic [31:0] DEV_STRIDE   = 32'h10,
   parameter int          DEV_SIZE     = 12,
   parameter int          DEV_WR_BYTES = 8,
   parameter logic [31:0] PRID         = 32'h4D49_5053
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [31:0]        addr_m,
   input  logic [31:0]        pc_m,
   input  logic               bd_m,
   input  logic [1:0]         ld_sel_m,
   input  logic [1:0]         st_sel_m,
   input  logic               ovf_m,
   input  logic               exc_in_m,
   input  logic [4:0]         exc_code_in_m,
   input  logic               eret_m,
   input  logic               cp0_we,
   input  logic [4:0]         cp0_waddr,
   input  logic [31:0]        cp0_wdata,
   input  logic [4:0]         cp0_raddr,
   output logic [31:0]        cp0_rdata,
   output logic               exc_req,
   output logic [4:0]         exc_code,
   output logic [31:0]        epc,
   output logic               exl
);

   logic [NUM_IRQ-1:0] r_irq_s1;
   logic [NUM_IRQ-1:0] r_irq_s2;
   logic [5:0]         r_im;
   logic               r_exl;
   logic               r_ie;
   logic               r_bd;
   logic [4:0]         r_exc_code;
   logic [31:0]        r_epc;

   logic [5:0]  w_ip;
   logic [3:0]  w_dev;
   logic [3:0]  w_devw;
   logic        w_dm;
   logic        w_int;
   logic        w_ld_fault;
   logic        w_st_fault;
   logic        w_any;
   logic        w_req;
   logic [4:0]  w_code;
   logic [31:0] w_pc_sel;
   logic [31:0] w_epc_exc;

   for (genvar k = 0; k < 6; k++) begin : g_ip
      if (k < NUM_IRQ) begin : g_line
         assign w_ip[k] = r_irq_s2[k];
      end else begin : g_none
         assign w_ip[k] = 1'b0;
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_dev
      if (k < NUM_DEV) begin : g_win
         localparam logic [31:0] c_base = DEV_BASE + DEV_STRIDE * 32'(k);
         logic [31:0] w_off;
         assign w_off     = addr_m - c_base;
         assign w_dev[k]  = (addr_m >= c_base) && (w_off < 32'(DEV_SIZE));
         assign w_devw[k] = w_dev[k] && (w_off < 32'(DEV_WR_BYTES));
      end else begin : g_nowin
         assign w_dev[k]  = 1'b0;
         assign w_devw[k] = 1'b0;
      end
   end

   // sel: 01 half, 10 byte, 11 word; word_ok is the word-access device window hit
   function automatic logic f_fault(input logic [1:0] sel, input logic [1:0] a_lo,
                                    input logic dm, input logic word_ok, input logic ovf);
      logic f;
      f = 1'b0;
      case (sel)
         2'b01:   f = a_lo[0] | ~dm;
         2'b10:   f = ~dm;
         2'b11:   f = (a_lo != 2'b00) | ~(dm | word_ok);
         default: f = 1'b0;
      endcase
      return f | (ovf & (sel != 2'b00));
   endfunction

   assign w_dm       = (addr_m <= DMEM_TOP);
   assign w_int      = r_ie & ~r_exl & (|(w_ip & r_im));
   assign w_ld_fault = f_fault(ld_sel_m, addr_m[1:0], w_dm, |w_dev, ovf_m);
   assign w_st_fault = f_fault(st_sel_m, addr_m[1:0], w_dm, |w_devw, ovf_m);
   assign w_any      = w_int | w_st_fault | w_ld_fault | exc_in_m;
   assign w_req      = w_any & ~r_exl & rst_n;

   always_comb begin
      w_code = 5'd0;
      if (w_int)           w_code = 5'd0;
      else if (w_st_fault) w_code = 5'd5;
      else if (w_ld_fault) w_code = 5'd4;
      else if (exc_in_m)   w_code = exc_code_in_m;
   end

   assign w_pc_sel  = bd_m ? (pc_m - 32'd4) : pc_m;
   assign w_epc_exc = w_pc_sel & 32'hFFFF_FFFC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_s1   <= '0;
         r_irq_s2   <= '0;
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         r_irq_s1 <= irq;
         r_irq_s2 <= r_irq_s1;
         if (w_req) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_code;
            r_bd       <= bd_m;
            r_epc      <= w_epc_exc;
         end else begin
            if (cp0_we && (cp0_waddr == 5'd12)) begin
               r_im  <= cp0_wdata[15:10];
               r_exl <= cp0_wdata[1];
               r_ie  <= cp0_wdata[0];
            end
            if (cp0_we && (cp0_waddr == 5'd14)) begin
               r_epc <= cp0_wdata & 32'hFFFF_FFFC;
            end
            // eret is ordered last so its EXL clear overrides a same-cycle SR write
            if (eret_m) begin
               r_exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_raddr)
         5'd12:   cp0_rdata = {16'b0, r_im, 8'b0, r_exl, r_ie};
         5'd13:   cp0_rdata = {r_bd, 15'b0, w_ip, 3'b0, r_exc_code, 2'b0};
         5'd14:   cp0_rdata = r_epc;
         5'd15:   cp0_rdata = PRID;
         default: cp0_rdata = 32'd0;
      endcase
   end

   assign exc_req  = w_req;
   assign exc_code = w_req ? w_code : 5'd0;
   assign epc      = r_epc;
   assign exl      = r_exl;

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
# exc_ctrl

Parametrised MEM-stage exception and interrupt controller with an integrated CP0 register file (SR, Cause, EPC, PRId). It synchronises up to six external interrupt lines and checks load/store addresses against a configurable data-memory and device map. It resolves exception priority and issues a single-cycle flush request to the pipeline. On each taken exception or `eret` it updates EXL/EPC/Cause, so interrupt gating and return-address handling live in one block.

## Interface
Parameters:
- `NUM_IRQ`, 6: external interrupt lines, 1..6, mapped to IM/IP bits 10..(9+NUM_IRQ).
- `DMEM_TOP`, 32'h0000_2FFF: last valid data-memory byte address (base 0).
- `NUM_DEV`, 2: device windows, 0..4.
- `DEV_BASE`, 32'h0000_7F00: base of device window 0.
- `DEV_STRIDE`, 32'h10: spacing between device windows.
- `DEV_SIZE`, 12: bytes per device window.
- `DEV_WR_BYTES`, 8: writable bytes at the start of each window; the rest is read-only.
- `PRID`, 32'h4D49_5053: PRId read value.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq` in NUM_IRQ: raw device interrupt levels, asynchronous.
- `addr_m` in 32: MEM-stage effective address.
- `pc_m` in 32: MEM-stage instruction PC.
- `bd_m` in 1: the MEM instruction is in a branch delay slot.
- `ld_sel_m` in 2: load size. 00 none, 01 half, 10 byte, 11 word.
- `st_sel_m` in 2: store size, same encoding as `ld_sel_m`.
- `ovf_m` in 1: overflow in the address calculation.
- `exc_in_m` in 1: an exception was raised in an earlier stage.
- `exc_code_in_m` in 5: ExcCode of that earlier-stage exception.
- `eret_m` in 1: `eret` is in MEM.
- `cp0_we` in 1: mtc0 write enable.
- `cp0_waddr` in 5: mtc0 target register.
- `cp0_wdata` in 32: mtc0 write data.
- `cp0_raddr` in 5: mfc0 source register.
- `cp0_rdata` out 32: mfc0 read data, combinational.
- `exc_req` out 1: take an exception this cycle; flush the pipeline.
- `exc_code` out 5: ExcCode of the exception being taken.
- `epc` out 32: current EPC register value.
- `exl` out 1: current SR.EXL.

## Operation
- **IRQ synchroniser:** each `irq` line passes through a 2-flop synchroniser. Cause.IP[9+k] holds the synchronised level (no latching). IP bits above NUM_IRQ read 0.
- **Interrupt condition:** `int_take = IE & ~EXL & |(IP & IM)`.
- **Data-memory hit:** `dm` = `addr_m` <= DMEM_TOP.
- **Device hit:** `dev_k` = DEV_BASE+k·DEV_STRIDE <= `addr_m` < that base + DEV_SIZE, for k < NUM_DEV.
- **Device writable:** `devw_k` is `dev_k` with offset < DEV_WR_BYTES.
- **Load fault:** any of the following.
  - half access with `addr_m[0]`=1;
  - word access with `addr_m[1:0]`≠0;
  - byte or half access outside `dm`;
  - word access outside (`dm` or any `dev_k`);
  - `ovf_m`=1 with a nonzero `ld_sel_m`.
- **Store fault:** same rules as load fault, but a word access must hit `dm` or any `devw_k`.
- **Priority:** interrupt (code 0) > store fault (5) > load fault (4) > `exc_in_m` (`exc_code_in_m`).
- **exc_req:** 1 when any source is active and EXL=0.
  - `exc_code` is the winning code; it is 0 when `exc_req`=0.
  - Both are combinational in the same cycle.
- **Taken-exception edge:** on the edge where `exc_req`=1:
  - EXL<=1;
  - Cause.ExcCode[6:2]<=`exc_code`;
  - Cause.BD[31]<=`bd_m`;
  - EPC<=`bd_m` ? `pc_m`-4 : `pc_m`, with bits [1:0] forced to 0.
- **eret:** on the edge where `eret_m`=1 and `exc_req`=0, EXL<=0.
- **mtc0:** applies on the edge only when `exc_req`=0.
  - Reg 12 writes IM[15:10], EXL[1] and IE[0].
  - Reg 14 writes EPC with bits [1:0] forced to 0.
  - Cause, PRId and all other registers are read-only.
- **mtc0 and eret together:** both apply; the eret clear of EXL wins over the written EXL bit.
- **mfc0:** reg 12 → `{16'b0, IM, 8'b0, EXL, IE}`; reg 13 → `{BD, 15'b0, IP[15:10], 3'b0, ExcCode, 2'b0}`; reg 14 → EPC; reg 15 → PRID; others → 0.

## Timing
- **Reset:** while `rst_n`=0 (asynchronous), SR=0, Cause=0, EPC=0, and the synchroniser flops are 0.
  - Outputs during reset: `exc_req`=0, `exc_code`=0, `epc`=0, `exl`=0, `cp0_rdata` reflects the zeroed registers.
- **Reset mid-operation:** assertion aborts any pending update.
- **IRQ latency:** a line asserted before edge N is visible in IP after edge N+1. `exc_req` can rise in the following cycle.
- **Taken exception:** `exc_req` is a one-cycle pulse per taken exception. EXL=1 after the edge blocks all further requests, faults included, until `eret`.
- **Register writes:** registered results (EXL, EPC, Cause) are visible on `cp0_rdata`/`epc`/`exl` the cycle after the edge. There is no write-to-read bypass.
- **Address boundaries:**
  - DMEM_TOP word 0x2FFC is in range; 0x3000 faults.
  - Device offset DEV_SIZE-4 is readable; offset DEV_SIZE faults.
  - Writes at offset DEV_WR_BYTES and above fault.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → all outputs 0 immediately; read PRId after reset release → 32'h4D49_5053.
- **Interrupt:** SR=32'h0000_0401, pulse `irq[0]` → `exc_req`=1, `exc_code`=0 two edges later; EPC=`pc_m`; `exl`=1; a second `irq` pulse gives no request until `eret`, then the request fires again.
- **Store alignment vs interrupt:** `st_sel_m`=11, `addr_m`=32'h0000_1002, no interrupt → `exc_code`=5. Same store with an interrupt pending → `exc_code`=0.
- **Device map:** word load at 32'h7F08 → no fault; word store at 32'h7F08 → code 5; word load at 32'h7F0C → code 4; word load at 32'h7F14 → no fault.
- **Delay slot:** exception with `bd_m`=1, `pc_m`=32'h3010 → EPC=32'h300C, Cause[31]=1.
- **Simultaneous events:** mtc0 to EPC in the same cycle as `exc_req` → EPC takes the exception value. `exc_in_m`=1 (code 12) while EXL=1 → no `exc_req`.
